// File: rtl/bp_be_dcache_decode_queue.sv
// bp_be_dcache_decode_queue
//   Registered, flow-controlled D$ opcode decoder. Packets arrive on a
//   ready/valid interface, are decoded at enqueue and buffered (raw packet
//   plus decoded pipeline word) in an els_p-deep circular queue ahead of the
//   tag-lookup stage. An enqueued fencei blocks further packets until the
//   fencei itself has been dequeued (fence-drain mode).
//
// Handshake: a packet transfers on a rising edge where v_i & ready_o; the head
//   transfers on a rising edge where yumi_i (only legal while v_o = 1). ready_o
//   depends on registered state only; v_o/pkt_o/decoded_o hold while yumi_i = 0.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   pkt_i, v_i, ready_o          : input packet channel
//   pkt_o, decoded_o, v_o, yumi_i: head of queue (raw + decoded)
//   count_o                      : occupancy
//   fence_busy_o                 : FSM is in e_drain
//
// Optional feature: define BP_BE_DCACHE_DECODE_BYPASS_EN to present an incoming
//   packet combinationally on the head outputs when the queue is empty.

package bp_be_dcache_decode_queue_pkg;
    // Cache level that services an atomic class.
    localparam int e_none = 0;
    localparam int e_l1   = 1;
    localparam int e_l2   = 2;

    typedef enum logic [5:0] {
        e_dcache_op_lb, e_dcache_op_lh, e_dcache_op_lw, e_dcache_op_ld,
        e_dcache_op_lbu, e_dcache_op_lhu, e_dcache_op_lwu,
        e_dcache_op_sb, e_dcache_op_sh, e_dcache_op_sw, e_dcache_op_sd,
        e_dcache_op_flw, e_dcache_op_fld, e_dcache_op_fsw, e_dcache_op_fsd,
        e_dcache_op_lrw, e_dcache_op_lrd, e_dcache_op_scw, e_dcache_op_scd,
        e_dcache_op_fencei,
        e_dcache_op_amoswapw, e_dcache_op_amoswapd,
        e_dcache_op_amoaddw, e_dcache_op_amoaddd,
        e_dcache_op_amoxorw, e_dcache_op_amoxord,
        e_dcache_op_amoandw, e_dcache_op_amoandd,
        e_dcache_op_amoorw, e_dcache_op_amoord,
        e_dcache_op_amominw, e_dcache_op_amomind,
        e_dcache_op_amomaxw, e_dcache_op_amomaxd,
        e_dcache_op_amominuw, e_dcache_op_amominud,
        e_dcache_op_amomaxuw, e_dcache_op_amomaxud
    } bp_be_dcache_op_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic        no_amo_return;
        logic [11:0] page_offset;
        logic [63:0] data;
    } bp_be_dcache_pkt_s;

    typedef struct packed {
        logic double_op, word_op, half_op, byte_op;
        logic fencei_op, float_op, lr_op, sc_op;
        logic amoswap_op, amoadd_op, amoxor_op, amoand_op, amoor_op;
        logic amomin_op, amomax_op, amominu_op, amomaxu_op;
        logic l2_op, no_return, load_op, store_op, signed_op;
    } bp_be_dcache_pipeline_s;
endpackage

module bp_be_dcache_decode_queue
    import bp_be_dcache_decode_queue_pkg::*;
#(
    parameter int bp_params_p            = 0,  // 0 = e_bp_default_cfg
    parameter int lr_sc_p                = (bp_params_p == 0) ? e_l1 : e_l2,
    parameter int amo_swap_p             = (bp_params_p == 0) ? e_none : e_l2,
    parameter int amo_fetch_logic_p      = (bp_params_p == 0) ? e_none : e_l2,
    parameter int amo_fetch_arithmetic_p = (bp_params_p == 0) ? e_none : e_l2,
    parameter int els_p                  = 2,
    localparam int lg_els_lp = $clog2(els_p + 1),
    localparam int pkt_w_lp  = $bits(bp_be_dcache_pkt_s),
    localparam int dec_w_lp  = $bits(bp_be_dcache_pipeline_s)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [pkt_w_lp-1:0]  pkt_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic [pkt_w_lp-1:0]  pkt_o,
    output logic [dec_w_lp-1:0]  decoded_o,
    output logic                 v_o,
    input  logic                 yumi_i,
    output logic [lg_els_lp-1:0] count_o,
    output logic                 fence_busy_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    typedef enum logic [0:0] {e_ready, e_drain} state_e;

    function automatic bp_be_dcache_pipeline_s decode(bp_be_dcache_pkt_s p);
        bp_be_dcache_pipeline_s d;
        d = '0;
        case (p.opcode)
            e_dcache_op_ld, e_dcache_op_lw, e_dcache_op_lh, e_dcache_op_lb:
                begin d.load_op = 1'b1; d.signed_op = 1'b1; end
            e_dcache_op_lwu, e_dcache_op_lhu, e_dcache_op_lbu:
                d.load_op = 1'b1;
            e_dcache_op_sd, e_dcache_op_sw, e_dcache_op_sh, e_dcache_op_sb:
                begin d.store_op = 1'b1; d.signed_op = 1'b1; end
            e_dcache_op_flw, e_dcache_op_fld:
                begin d.load_op = 1'b1; d.float_op = 1'b1; end
            e_dcache_op_fsw, e_dcache_op_fsd:
                begin d.store_op = 1'b1; d.float_op = 1'b1; end
            e_dcache_op_fencei:
                begin d.fencei_op = 1'b1; d.signed_op = 1'b1; end
            e_dcache_op_lrw, e_dcache_op_lrd: begin
                d.lr_op = 1'b1; d.load_op = 1'b1; d.signed_op = 1'b1;
                d.l2_op = (lr_sc_p == e_l2); d.no_return = p.no_amo_return;
            end
            e_dcache_op_scw, e_dcache_op_scd: begin
                d.sc_op = 1'b1; d.store_op = 1'b1; d.signed_op = 1'b1;
                d.l2_op = (lr_sc_p == e_l2); d.no_return = p.no_amo_return;
            end
            e_dcache_op_amoswapw, e_dcache_op_amoswapd:
                begin d.amoswap_op = 1'b1; d.l2_op = (amo_swap_p == e_l2); end
            e_dcache_op_amoxorw, e_dcache_op_amoxord:
                begin d.amoxor_op = 1'b1; d.l2_op = (amo_fetch_logic_p == e_l2); end
            e_dcache_op_amoandw, e_dcache_op_amoandd:
                begin d.amoand_op = 1'b1; d.l2_op = (amo_fetch_logic_p == e_l2); end
            e_dcache_op_amoorw, e_dcache_op_amoord:
                begin d.amoor_op = 1'b1; d.l2_op = (amo_fetch_logic_p == e_l2); end
            e_dcache_op_amoaddw, e_dcache_op_amoaddd:
                begin d.amoadd_op = 1'b1; d.l2_op = (amo_fetch_arithmetic_p == e_l2); end
            e_dcache_op_amominw, e_dcache_op_amomind:
                begin d.amomin_op = 1'b1; d.l2_op = (amo_fetch_arithmetic_p == e_l2); end
            e_dcache_op_amomaxw, e_dcache_op_amomaxd:
                begin d.amomax_op = 1'b1; d.l2_op = (amo_fetch_arithmetic_p == e_l2); end
            e_dcache_op_amominuw, e_dcache_op_amominud:
                begin d.amominu_op = 1'b1; d.l2_op = (amo_fetch_arithmetic_p == e_l2); end
            e_dcache_op_amomaxuw, e_dcache_op_amomaxud:
                begin d.amomaxu_op = 1'b1; d.l2_op = (amo_fetch_arithmetic_p == e_l2); end
            default: ;
        endcase
        // Every AMO shares the read-modify-write attributes.
        if (p.opcode >= e_dcache_op_amoswapw && p.opcode <= e_dcache_op_amomaxud) begin
            d.load_op = 1'b1; d.store_op = 1'b1; d.signed_op = 1'b1;
            d.no_return = p.no_amo_return;
        end
        case (p.opcode)
            e_dcache_op_ld, e_dcache_op_sd, e_dcache_op_fld, e_dcache_op_fsd,
            e_dcache_op_lrd, e_dcache_op_scd, e_dcache_op_amoswapd,
            e_dcache_op_amoaddd, e_dcache_op_amoxord, e_dcache_op_amoandd,
            e_dcache_op_amoord, e_dcache_op_amomind, e_dcache_op_amomaxd,
            e_dcache_op_amominud, e_dcache_op_amomaxud:
                d.double_op = 1'b1;
            e_dcache_op_lw, e_dcache_op_lwu, e_dcache_op_sw, e_dcache_op_flw,
            e_dcache_op_fsw, e_dcache_op_lrw, e_dcache_op_scw, e_dcache_op_amoswapw,
            e_dcache_op_amoaddw, e_dcache_op_amoxorw, e_dcache_op_amoandw,
            e_dcache_op_amoorw, e_dcache_op_amominw, e_dcache_op_amomaxw,
            e_dcache_op_amominuw, e_dcache_op_amomaxuw:
                d.word_op = 1'b1;
            e_dcache_op_lh, e_dcache_op_lhu, e_dcache_op_sh: d.half_op = 1'b1;
            e_dcache_op_lb, e_dcache_op_lbu, e_dcache_op_sb: d.byte_op = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

    bp_be_dcache_pkt_s      pkt_mem [els_p];
    bp_be_dcache_pipeline_s dec_mem [els_p];
    bp_be_dcache_pipeline_s dec_in;
    logic [ptr_w_lp-1:0]    rptr, wptr;
    logic [lg_els_lp-1:0]   count;
    state_e                 state;
    logic                   fence_busy_r;
    logic                   empty, enq, bypass, wr, mem_rd;

    assign dec_in  = decode(bp_be_dcache_pkt_s'(pkt_i));
    assign empty   = (count == '0);
    assign ready_o = (state == e_ready) && (count < lg_els_lp'(els_p));
    assign enq     = v_i & ready_o;

`ifdef BP_BE_DCACHE_DECODE_BYPASS_EN
    assign bypass = empty & enq;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed packet consumed in the same cycle never touches storage.
    assign wr     = enq & ~(bypass & yumi_i);
    assign mem_rd = yumi_i & ~empty;

    assign v_o          = ~empty | bypass;
    assign pkt_o        = bypass ? pkt_i : pkt_w_lp'(pkt_mem[rptr]);
    assign decoded_o    = bypass ? dec_w_lp'(dec_in) : dec_w_lp'(dec_mem[rptr]);
    assign count_o      = count;
    assign fence_busy_o = fence_busy_r;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (wr) begin
            pkt_mem[wptr] <= bp_be_dcache_pkt_s'(pkt_i);
            dec_mem[wptr] <= dec_in;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= e_ready;
            fence_busy_r <= 1'b0;
            count        <= '0;
            rptr         <= '0;
            wptr         <= '0;
        end else begin
            count <= count + lg_els_lp'(wr) - lg_els_lp'(mem_rd);
            if (wr)     wptr <= ptr_inc(wptr);
            if (mem_rd) rptr <= ptr_inc(rptr);
            case (state)
                e_ready: if (wr && dec_in.fencei_op) begin
                    state        <= e_drain;
                    fence_busy_r <= 1'b1;
                end
                e_drain: if (mem_rd && dec_mem[rptr].fencei_op) begin
                    state        <= e_ready;
                    fence_busy_r <= 1'b0;
                end
                default: begin
                    state        <= e_ready;
                    fence_busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bp_be_dcache_decode_queue.sv
module tb_bp_be_dcache_decode_queue;
    import bp_be_dcache_decode_queue_pkg::*;

    localparam int ELS = 2;
    localparam int PW  = $bits(bp_be_dcache_pkt_s);
    localparam int DW  = $bits(bp_be_dcache_pipeline_s);
    localparam int CW  = $clog2(ELS + 1);

    // ---------------- clock / reset ----------------
    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [PW-1:0] pkt_i = '0;
    logic          v_i = 1'b0;
    logic          ready_o;
    logic [PW-1:0] pkt_o;
    logic [DW-1:0] decoded_o;
    logic          v_o;
    logic          yumi_i = 1'b0;
    logic [CW-1:0] count_o;
    logic          fence_busy_o;

    always #5 clk_i = ~clk_i;

    bp_be_dcache_decode_queue #(
        .amo_fetch_arithmetic_p(e_l2),
        .els_p(ELS)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .pkt_i(pkt_i), .v_i(v_i),
        .ready_o(ready_o), .pkt_o(pkt_o), .decoded_o(decoded_o), .v_o(v_o),
        .yumi_i(yumi_i), .count_o(count_o), .fence_busy_o(fence_busy_o)
    );

    // ---------------- scoreboard ----------------
    logic [PW+DW-1:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every head transfer is compared against the oldest expectation.
    always @(negedge clk_i) begin
        if (!reset_i && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL monitor_unexpected: got head %0h expected none", {pkt_o, decoded_o});
            end else begin
                check("monitor_head", 128'({pkt_o, decoded_o}), 128'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic bp_be_dcache_pkt_s mk_pkt(input logic [5:0] op, input logic nar);
        bp_be_dcache_pkt_s p;
        p.opcode        = op;
        p.no_amo_return = nar;
        p.page_offset   = 12'($urandom_range(0, 4095));
        p.data          = {$urandom, $urandom};
        return p;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input bp_be_dcache_pkt_s p, input bp_be_dcache_pipeline_s e);
        pkt_i = p;
        v_i   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (ready_o) begin
                exp_q.push_back({p, e});
                @(posedge clk_i);
                #1 v_i = 1'b0;
                return;
            end
        end
        v_i = 1'b0;
        checks++;
        $display("FAIL send_timeout: got ready_o=0 expected 1 within 50 cycles");
    endtask

    task automatic drain_one();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_i);
            #1;
            if (v_o) begin
                yumi_i = 1'b1;
                @(posedge clk_i);
                #1 yumi_i = 1'b0;
                return;
            end
        end
        checks++;
        $display("FAIL drain_timeout: got v_o=0 expected 1 within 50 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    bp_be_dcache_pipeline_s e_lw, e_sb, e_lhu, e_sd, e_fi, e_ld, e_amo, e_lrw, e_swp, e_fsw, e_unk, e_sh, e_lbu;

    initial begin
        e_lw  = '0; e_lw.load_op = 1; e_lw.signed_op = 1; e_lw.word_op = 1;
        e_sb  = '0; e_sb.store_op = 1; e_sb.signed_op = 1; e_sb.byte_op = 1;
        e_lhu = '0; e_lhu.load_op = 1; e_lhu.half_op = 1;
        e_sd  = '0; e_sd.store_op = 1; e_sd.signed_op = 1; e_sd.double_op = 1;
        e_fi  = '0; e_fi.fencei_op = 1; e_fi.signed_op = 1;
        e_ld  = '0; e_ld.load_op = 1; e_ld.signed_op = 1; e_ld.double_op = 1;
        e_amo = '0; e_amo.load_op = 1; e_amo.store_op = 1; e_amo.signed_op = 1;
        e_amo.amoadd_op = 1; e_amo.double_op = 1; e_amo.l2_op = 1; e_amo.no_return = 1;
        e_lrw = '0; e_lrw.lr_op = 1; e_lrw.load_op = 1; e_lrw.signed_op = 1;
        e_lrw.word_op = 1; e_lrw.no_return = 1;
        e_swp = '0; e_swp.load_op = 1; e_swp.store_op = 1; e_swp.signed_op = 1;
        e_swp.amoswap_op = 1; e_swp.word_op = 1;
        e_fsw = '0; e_fsw.store_op = 1; e_fsw.float_op = 1; e_fsw.word_op = 1;
        e_unk = '0;
        e_sh  = '0; e_sh.store_op = 1; e_sh.signed_op = 1; e_sh.half_op = 1;
        e_lbu = '0; e_lbu.load_op = 1; e_lbu.byte_op = 1;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_ready", 128'(ready_o), 128'(1));
        check("reset_v", 128'(v_o), 128'(0));
        check("reset_count", 128'(count_o), 128'(0));
        check("reset_fence_busy", 128'(fence_busy_o), 128'(0));
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Single lw, visible after the accepting edge
        send(mk_pkt(e_dcache_op_lw, 1'b0), e_lw);
        check("lw_v", 128'(v_o), 128'(1));
        check("lw_count", 128'(count_o), 128'(1));
        check("lw_decoded", 128'(decoded_o), 128'(e_lw));
        drain_one();

        // Fill to depth, third packet held, in-order drain
        send(mk_pkt(e_dcache_op_sb, 1'b0), e_sb);
        send(mk_pkt(e_dcache_op_lhu, 1'b0), e_lhu);
        pkt_i = mk_pkt(e_dcache_op_sd, 1'b0);
        v_i   = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            check("full_ready", 128'(ready_o), 128'(0));
            check("full_count", 128'(count_o), 128'(2));
        end
        fork
            send(mk_pkt(e_dcache_op_sd, 1'b0), e_sd);
            begin drain_one(); drain_one(); drain_one(); end
        join

        // fencei blocks ld until it has been dequeued
        send(mk_pkt(e_dcache_op_fencei, 1'b0), e_fi);
        check("fence_busy_set", 128'(fence_busy_o), 128'(1));
        fork
            send(mk_pkt(e_dcache_op_ld, 1'b0), e_ld);
            begin
                repeat (2) begin
                    @(negedge clk_i);
                    check("fence_ready_blocked", 128'(ready_o), 128'(0));
                    check("fence_count", 128'(count_o), 128'(1));
                end
                drain_one();
                check("fence_busy_clear", 128'(fence_busy_o), 128'(0));
                check("fence_ready_open", 128'(ready_o), 128'(1));
            end
        join
        check("ld_after_fence_count", 128'(count_o), 128'(1));
        drain_one();

        // Atomics, LR, FP store, unknown opcode
        fork
            begin
                send(mk_pkt(e_dcache_op_amoaddd, 1'b1), e_amo);
                send(mk_pkt(e_dcache_op_lrw, 1'b1), e_lrw);
                send(mk_pkt(e_dcache_op_amoswapw, 1'b0), e_swp);
                send(mk_pkt(e_dcache_op_fsw, 1'b0), e_fsw);
                send(mk_pkt(6'h3f, 1'b1), e_unk);
            end
            begin repeat (5) drain_one(); end
        join

        // Asynchronous reset with two entries queued
        send(mk_pkt(e_dcache_op_sb, 1'b0), e_sb);
        send(mk_pkt(e_dcache_op_sh, 1'b0), e_sh);
        check("pre_reset_count", 128'(count_o), 128'(2));
        #2 reset_i = 1'b1;
        #1;
        check("async_reset_v", 128'(v_o), 128'(0));
        check("async_reset_count", 128'(count_o), 128'(0));
        check("async_reset_ready", 128'(ready_o), 128'(1));
        exp_q.delete();
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        @(posedge clk_i);
        #1;

`ifdef BP_BE_DCACHE_DECODE_BYPASS_EN
        // Bypass: empty queue, lbu taken in the same cycle it arrives
        pkt_i  = mk_pkt(e_dcache_op_lbu, 1'b0);
        exp_q.push_back({pkt_i, e_lbu});
        v_i    = 1'b1;
        yumi_i = 1'b1;
        #1;
        check("bypass_v", 128'(v_o), 128'(1));
        check("bypass_decoded", 128'(decoded_o), 128'(e_lbu));
        @(posedge clk_i);
        #1 v_i = 1'b0;
        yumi_i = 1'b0;
        check("bypass_count", 128'(count_o), 128'(0));
`endif

        repeat (3) @(posedge clk_i);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
